imem_boot_loader: RTL and testbench

- Hardware counterpart to the bench-side memory preload: receives a program image as a byte stream and writes it word-by-word into instruction memory.
- Holds the pipeline core in reset until the image is fully written, then releases it.
- Sits between an external byte source (UART/debug bridge) and the instruction-memory write port plus the core reset input of pipeline_top.

---
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 tb/tb_imem_boot_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: takes a length header and a little-endian word image,
// writes it into instruction memory and holds the core in reset until the image is in.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written,
    output logic [2:0]        state_dbg
);

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
    // byte_ready depends on the state alone, never on byte_valid.
    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'd1 << ADDR_W;

    state_t              state_q;
    logic [7:0]          len_lo_q;
    logic [ADDR_W:0]     n_q;
    logic [1:0]          lane_q;
    logic [23:0]         asm_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                core_rst_n_q;
    logic                done_q;
    logic                error_q;
    logic [ADDR_W:0]     words_written_q;

    logic                xfer;
    logic [15:0]         n_hdr;
    logic [ADDR_W:0]     ww_inc;
    logic [DATA_W-1:0]   word_full;

    assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
    assign xfer       = byte_valid && byte_ready;
    assign n_hdr      = {byte_data, len_lo_q};
    assign ww_inc     = words_written_q + 1'b1;
    assign word_full  = {byte_data, asm_q};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= S_LEN0;
            len_lo_q        <= '0;
            n_q             <= '0;
            lane_q          <= '0;
            asm_q           <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            core_rst_n_q    <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            words_written_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (load_start) begin
                // Restart wins over any byte offered on this edge; that byte is dropped.
                state_q         <= S_LEN0;
                core_rst_n_q    <= 1'b0;
                done_q          <= 1'b0;
                error_q         <= 1'b0;
                words_written_q <= '0;
                lane_q          <= '0;
                asm_q           <= '0;
            end else begin
                case (state_q)
                    S_LEN0: if (xfer) begin
                        len_lo_q <= byte_data;
                        state_q  <= S_LEN1;
                    end
                    S_LEN1: if (xfer) begin
                        if (n_hdr == 16'd0) begin
                            state_q <= S_DONE;
                        end else if ({1'b0, n_hdr} > DEPTH_L) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            n_q             <= n_hdr[ADDR_W:0];
                            lane_q          <= '0;
                            words_written_q <= '0;
                            state_q         <= S_DATA;
                        end
                    end
                    S_DATA: if (xfer) begin
                        lane_q <= lane_q + 2'd1;
                        if (lane_q != 2'd3) begin
                            asm_q[{lane_q, 3'b000} +: 8] <= byte_data;
                        end else begin
                            mem_wdata_q     <= word_full;
                            mem_addr_q      <= words_written_q[ADDR_W-1:0];
                            mem_we_q        <= 1'b1;
                            words_written_q <= ww_inc;
                            if (ww_inc == n_q) state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        core_rst_n_q <= 1'b1;
                        done_q       <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign core_rst_n    = core_rst_n_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_written_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: randomized images checked against a word-level
// model of the stream format; writes are scored by an expected-write queue.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              load_start = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready, mem_we, core_rst_n, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_written;
  logic [2:0]        state_dbg;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .load_start(load_start),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .done(done), .error(error),
    .words_written(words_written), .state_dbg(state_dbg)
  );

  // clock / reset / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  logic [31:0] img_q[$];

  // scoreboard: every write strobe must match the oldest expected {addr, data}
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                   mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int guard;
    guard = 0;
    byte_data = b;
    byte_valid = 1'b1;
    do begin
      @(negedge CLK);
      rdy = byte_ready;
      @(posedge CLK);
      #1;
      guard++;
    end while (!rdy && guard < 64);
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL send_byte_timeout: byte %02h not accepted within %0d cycles", b, guard);
    end
  endtask

  task automatic idle(input int k);
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge CLK);
    #1;
    load_start = 1'b0;
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
  endtask

  // Sends the first nw words of img_q after a header of n.
  task automatic send_image(input int n, input int nw, input bit gaps);
    logic [15:0] hdr;
    logic [31:0] w;
    hdr = 16'(n);
    send_byte(hdr[7:0]);
    maybe_gap(gaps);
    send_byte(hdr[15:8]);
    for (int i = 0; i < nw; i++) begin
      w = img_q[i];
      for (int l = 0; l < 4; l++) begin
        maybe_gap(gaps);
        send_byte(8'(w >> (8 * l)));
      end
    end
  endtask

  // model: word i of the image lands at address i
  task automatic expect_image(input int nw);
    for (int i = 0; i < nw; i++) exp_q.push_back({8'(i), img_q[i]});
  endtask

  task automatic random_image(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back($urandom);
  endtask

  // tests
  task automatic test_reset();
    RST = 1'b0;
    #3;
    total++;
    if ({core_rst_n, mem_we, mem_addr, mem_wdata, done, error, words_written, byte_ready, state_dbg}
        !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 9'd0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL reset_outputs: crst=%b we=%b addr=%0d wd=%08h done=%b err=%b ww=%0d rdy=%b st=%0d, expected 0 0 0 0 0 0 0 1 0",
               core_rst_n, mem_we, mem_addr, mem_wdata, done, error, words_written, byte_ready, state_dbg);
    end
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    img_q.delete();
    img_q.push_back(32'h00100013);
    img_q.push_back(32'h00200093);
    expect_image(2);
    send_image(2, 2, 1'b0);
    total++;
    if (mem_we !== 1'b1 || core_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL basic_last_write: we=%b crst=%b, expected we=1 crst=0", mem_we, core_rst_n);
    end
    byte_valid = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if ({core_rst_n, done, words_written, mem_we, byte_ready} !== {1'b1, 1'b1, 9'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_release: crst=%b done=%b ww=%0d we=%b rdy=%b, expected 1 1 2 0 0",
               core_rst_n, done, words_written, mem_we, byte_ready);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_writes: %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    byte_valid = 1'b0;
    total++;
    if (core_rst_n !== 1'b0 || state_dbg !== 3'd3) begin
      bad++;
      $display("FAIL zero_len_first: crst=%b st=%0d, expected crst=0 st=3", core_rst_n, state_dbg);
    end
    @(posedge CLK);
    #1;
    total++;
    if ({core_rst_n, done, words_written, error} !== {1'b1, 1'b1, 9'd0, 1'b0}) begin
      bad++;
      $display("FAIL zero_len_release: crst=%b done=%b ww=%0d err=%b, expected 1 1 0 0",
               core_rst_n, done, words_written, error);
    end
  endtask

  task automatic test_error();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    byte_valid = 1'b0;
    total++;
    if ({error, byte_ready, core_rst_n, done} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL error_enter: err=%b rdy=%b crst=%b done=%b, expected 1 0 0 0",
               error, byte_ready, core_rst_n, done);
    end
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_data = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    byte_valid = 1'b0;
    total++;
    if ({error, core_rst_n, done, words_written} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
      bad++;
      $display("FAIL error_hold: err=%b crst=%b done=%b ww=%0d, expected 1 0 0 0",
               error, core_rst_n, done, words_written);
    end
    pulse_start();
    total++;
    if (error !== 1'b0 || byte_ready !== 1'b1) begin
      bad++;
      $display("FAIL error_clear: err=%b rdy=%b, expected 0 1", error, byte_ready);
    end
    random_image(1);
    expect_image(1);
    send_image(1, 1, 1'b0);
    byte_valid = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL error_reload: done=%b missing=%0d, expected done=1 missing=0", done, exp_q.size());
    end
  endtask

  task automatic test_gaps();
    random_image(3);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      expect_image(3);
      send_image(3, 3, pass == 1);
      byte_valid = 1'b0;
      @(posedge CLK);
      #1;
      total++;
      if (done !== 1'b1 || words_written !== 9'd3 || exp_q.size() != 0) begin
        bad++;
        $display("FAIL gaps_pass%0d: done=%b ww=%0d missing=%0d, expected 1 3 0",
                 pass, done, words_written, exp_q.size());
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] w1;
    pulse_start();
    random_image(3);
    expect_image(1);
    send_image(3, 1, 1'b0);
    w1 = img_q[1];
    send_byte(w1[7:0]);
    send_byte(w1[15:8]);
    byte_data = w1[23:16];
    load_start = 1'b1;
    @(posedge CLK);
    #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    total++;
    if ({words_written, done, core_rst_n, state_dbg} !== {9'd0, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL abort_state: ww=%0d done=%b crst=%b st=%0d, expected 0 0 0 0",
               words_written, done, core_rst_n, state_dbg);
    end
    img_q.delete();
    img_q.push_back(32'hDDCCBBAA);
    expect_image(1);
    send_image(1, 1, 1'b0);
    byte_valid = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (done !== 1'b1 || words_written !== 9'd1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_reload: done=%b ww=%0d missing=%0d, expected 1 1 0",
               done, words_written, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w2;
    pulse_start();
    random_image(3);
    expect_image(2);
    send_image(3, 2, 1'b0);
    w2 = img_q[2];
    send_byte(w2[7:0]);
    send_byte(w2[15:8]);
    byte_valid = 1'b0;
    total++;
    if (words_written !== 9'd2 || mem_addr !== 8'd1) begin
      bad++;
      $display("FAIL areset_pre: ww=%0d addr=%0d, expected 2 1", words_written, mem_addr);
    end
    #2;
    RST = 1'b0;
    #1;
    total++;
    if ({core_rst_n, mem_we, mem_addr, mem_wdata, done, error, words_written, byte_ready, state_dbg}
        !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 9'd0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL areset_outputs: crst=%b we=%b addr=%0d wd=%08h done=%b err=%b ww=%0d rdy=%b st=%0d, expected 0 0 0 0 0 0 0 1 0",
               core_rst_n, mem_we, mem_addr, mem_wdata, done, error, words_written, byte_ready, state_dbg);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (state_dbg !== 3'd0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL areset_after: st=%0d missing=%0d, expected 0 0", state_dbg, exp_q.size());
    end
  endtask

  task automatic test_full_depth();
    random_image(DEPTH);
    expect_image(DEPTH);
    send_image(DEPTH, DEPTH, 1'b0);
    byte_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'(DEPTH - 1)) begin
      bad++;
      $display("FAIL full_last: we=%b addr=%0d, expected 1 %0d", mem_we, mem_addr, DEPTH - 1);
    end
    @(posedge CLK);
    #1;
    total++;
    if (done !== 1'b1 || words_written !== 9'(DEPTH) || error !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL full_done: done=%b ww=%0d err=%b missing=%0d, expected 1 %0d 0 0",
               done, words_written, error, exp_q.size(), DEPTH);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      pulse_start();
      n = $urandom_range(1, 6);
      random_image(n);
      expect_image(n);
      send_image(n, n, $urandom_range(0, 1) == 1);
      byte_valid = 1'b0;
      @(posedge CLK);
      #1;
      total++;
      if (done !== 1'b1 || core_rst_n !== 1'b1 || words_written !== 9'(n) || exp_q.size() != 0) begin
        bad++;
        $display("FAIL random_%0d: done=%b crst=%b ww=%0d missing=%0d, expected 1 1 %0d 0",
                 it, done, core_rst_n, words_written, exp_q.size(), n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_gaps();
    test_abort();
    test_async_reset();
    test_full_depth();
    pulse_start();
    test_random();
    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
